pc_gen: RTL and testbench

Parametrised program-counter generator for the fetch stage: holds the current PC, selects the next PC from sequential, branch/jump, return-prediction and trap sources, and keeps a small return-address stack (RAS). Successor of the single-register PC: adds configurable width, reset/trap vectors, stall, computed redirect with alignment check, and call/return prediction. Sits between the branch-resolution AND logic and instruction memory.

---
 rtl/pc_gen_pkg.sv | 24 ++
 rtl/pc_gen_if.sv | 35 +++
 rtl/pc_gen_ras_stack.sv | 57 +++++
 rtl/pc_gen.sv | 94 +++++++++
 tb/tb_pc_gen.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/pc_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pc_pkg
// Brief   : Shared constants and next-PC source encoding for pc_gen.
// Revision: 1.0 - initial release
// ============================================================================
package pc_pkg;

  localparam int          DEF_XLEN         = 32;
  localparam int          INSTR_BYTES      = 4;
  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VECTOR  = 32'h0000_0100;

  typedef enum logic [2:0] {
    SRC_RESET    = 3'd0,
    SRC_TRAP     = 3'd1,
    SRC_REDIRECT = 3'd2,
    SRC_HOLD     = 3'd3,
    SRC_RET      = 3'd4,
    SRC_SEQ      = 3'd5
  } pc_src_e;

endpackage
`default_nettype wire

// File: rtl/pc_gen_if.sv
`default_nettype none
// ============================================================================
// Module  : pc_gen_if
// Brief   : Control inputs and fetch-address outputs of the PC generator.
// Revision: 1.0 - initial release
// ============================================================================
interface pc_gen_if
  import pc_pkg::*;
#(
  parameter int XLEN = DEF_XLEN
);
  logic            stall;
  logic            trap;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_base;
  logic [XLEN-1:0] redirect_imm;
  logic            call;
  logic            ret;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4;
  logic            ras_empty;
  logic            ras_full;
  logic            misaligned;

  modport master (
    output stall, trap, redirect_valid, redirect_base, redirect_imm, call, ret,
    input  pc, pc_plus4, ras_empty, ras_full, misaligned
  );

  modport slave (
    input  stall, trap, redirect_valid, redirect_base, redirect_imm, call, ret,
    output pc, pc_plus4, ras_empty, ras_full, misaligned
  );
endinterface
`default_nettype wire

// File: rtl/pc_gen_ras_stack.sv
`default_nettype none
// ============================================================================
// Module  : ras_stack
// Brief   : Circular return-address stack; a push when full overwrites the oldest.
// Revision: 1.0 - initial release
// ============================================================================
module ras_stack #(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 4
) (
  input  wire logic            clock,
  input  wire logic            reset,
  input  wire logic            push,
  input  wire logic            pop,
  input  wire logic            clear,
  input  wire logic [XLEN-1:0] push_data,
  output logic      [XLEN-1:0] top,
  output logic                 empty,
  output logic                 full
);
  localparam int c_PTR_W = $clog2(RAS_DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam logic [c_PTR_W-1:0] c_PTR_ONE = 1;
  localparam logic [c_CNT_W-1:0] c_CNT_ONE = 1;
  localparam logic [c_CNT_W-1:0] c_DEPTH   = RAS_DEPTH[c_CNT_W-1:0];

  logic [XLEN-1:0]    r_mem [RAS_DEPTH];
  logic [c_PTR_W-1:0] r_sp;      // next free slot; top lives one below
  logic [c_CNT_W-1:0] r_count;
  logic [c_PTR_W-1:0] w_top_idx;

  assign w_top_idx = r_sp - c_PTR_ONE;
  assign top       = r_mem[w_top_idx];
  assign empty     = (r_count == '0);
  assign full      = (r_count == c_DEPTH);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_sp    <= '0;
      r_count <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) r_mem[i] <= '0;
    end else if (clear) begin
      r_sp    <= '0;
      r_count <= '0;
    end else if (push && pop && !empty) begin
      r_mem[w_top_idx] <= push_data;
    end else if (push) begin
      r_mem[r_sp] <= push_data;
      r_sp        <= r_sp + c_PTR_ONE;
      if (!full) r_count <= r_count + c_CNT_ONE;
    end else if (pop && !empty) begin
      r_sp    <= w_top_idx;
      r_count <= r_count - c_CNT_ONE;
    end
  end
endmodule
`default_nettype wire

// File: rtl/pc_gen.sv
`default_nettype none
// ============================================================================
// Module  : pc_gen
// Brief   : Fetch-stage PC register with redirect, trap, stall and RAS prediction.
// Revision: 1.0 - initial release
// ============================================================================
module pc_gen
  import pc_pkg::*;
#(
  parameter int              XLEN         = DEF_XLEN,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEF_RESET_VECTOR),
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(DEF_TRAP_VECTOR),
  parameter int              RAS_DEPTH    = 4
) (
  input  wire logic clock,
  input  wire logic reset,
  pc_gen_if.slave   bus
);
  logic [XLEN-1:0] r_pc;
  logic            r_misaligned;
  logic [XLEN-1:0] w_pc_plus4;
  logic [XLEN-1:0] w_target;
  logic            w_target_mis;
  logic [XLEN-1:0] w_ras_top;
  logic            w_ras_empty;
  logic            w_ras_full;
  logic            w_ras_act;
  pc_src_e         w_src;
  logic [XLEN-1:0] w_next_pc;

  assign w_pc_plus4 = r_pc + XLEN'(INSTR_BYTES);

  // Bit 0 is dropped; only bit 1 decides misalignment of the target.
  always_comb begin
    w_target     = bus.redirect_base + bus.redirect_imm;
    w_target[0]  = 1'b0;
    w_target_mis = w_target[1];
  end

  always_comb begin
    w_src = SRC_SEQ;
    if (reset)                            w_src = SRC_RESET;
    else if (bus.trap)                    w_src = SRC_TRAP;
    else if (bus.redirect_valid)          w_src = SRC_REDIRECT;
    else if (bus.stall)                   w_src = SRC_HOLD;
    else if (bus.ret && !w_ras_empty)     w_src = SRC_RET;
  end

  always_comb begin
    w_next_pc = w_pc_plus4;
    case (w_src)
      SRC_RESET:    w_next_pc = RESET_VECTOR;
      SRC_TRAP:     w_next_pc = TRAP_VECTOR;
      SRC_REDIRECT: w_next_pc = w_target_mis ? TRAP_VECTOR : w_target;
      SRC_HOLD:     w_next_pc = r_pc;
      SRC_RET:      w_next_pc = w_ras_top;
      default:      w_next_pc = w_pc_plus4;
    endcase
  end

  assign w_ras_act = (w_src == SRC_RET) || (w_src == SRC_SEQ);

  ras_stack #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clock     (clock),
    .reset     (reset),
    .push      (w_ras_act && bus.call),
    .pop       (w_ras_act && bus.ret && !w_ras_empty),
    .clear     (bus.trap),
    .push_data (w_pc_plus4),
    .top       (w_ras_top),
    .empty     (w_ras_empty),
    .full      (w_ras_full)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_pc         <= RESET_VECTOR;
      r_misaligned <= 1'b0;
    end else begin
      r_pc         <= w_next_pc;
      r_misaligned <= (w_src == SRC_REDIRECT) && w_target_mis;
    end
  end

  assign bus.pc         = r_pc;
  assign bus.pc_plus4   = w_pc_plus4;
  assign bus.ras_empty  = w_ras_empty;
  assign bus.ras_full   = w_ras_full;
  assign bus.misaligned = r_misaligned;
endmodule
`default_nettype wire

// File: tb/tb_pc_gen.sv
`default_nettype none
// ============================================================================
// Module  : tb_pc_gen
// Brief   : Directed vector bench for pc_gen (RAS_DEPTH=4, trap vector 0x100).
// Revision: 1.0 - initial release
// ============================================================================
module tb_pc_gen;
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  pc_gen_if #(.XLEN(32)) bus ();

  pc_gen #(
    .XLEN         (32),
    .RESET_VECTOR (32'h0000_0000),
    .TRAP_VECTOR  (32'h0000_0100),
    .RAS_DEPTH    (4)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        rst, stl, trp, rv;
    logic [31:0] base, imm;
    logic        cl, rt;
    logic [31:0] e_pc;
    logic        e_emp, e_full, e_mis;
  } vec_t;

  vec_t vq[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic step(input logic rst, stl, trp, rv, input logic [31:0] base, imm,
                      input logic cl, rt);
    reset              = rst;
    bus.stall          = stl;
    bus.trap           = trp;
    bus.redirect_valid = rv;
    bus.redirect_base  = base;
    bus.redirect_imm   = imm;
    bus.call           = cl;
    bus.ret            = rt;
    @(posedge clock);
    #1;
  endtask

  initial begin
    //            rst stl trp rv  base          imm           cl rt  pc            emp full mis
    vq.push_back('{1, 0, 0, 0, 32'h0,        32'h0,        0, 0, 32'h0,        1, 0, 0});
    vq.push_back('{1, 0, 0, 0, 32'h0,        32'h0,        0, 0, 32'h0,        1, 0, 0});
    vq.push_back('{0, 0, 0, 0, 32'h0,        32'h0,        0, 0, 32'h4,        1, 0, 0});
    vq.push_back('{0, 0, 0, 0, 32'h0,        32'h0,        0, 0, 32'h8,        1, 0, 0});
    vq.push_back('{0, 0, 0, 0, 32'h0,        32'h0,        0, 0, 32'hC,        1, 0, 0});
    vq.push_back('{0, 0, 0, 1, 32'hC,        32'h34,       0, 0, 32'h40,       1, 0, 0});
    vq.push_back('{0, 0, 0, 1, 32'h40,       32'hFFFF_FFF0,0, 0, 32'h30,       1, 0, 0});
    vq.push_back('{0, 0, 0, 1, 32'h40,       32'h6,        0, 0, 32'h100,      1, 0, 1});
    vq.push_back('{0, 0, 0, 0, 32'h0,        32'h0,        0, 0, 32'h104,      1, 0, 0});
    vq.push_back('{0, 0, 1, 1, 32'h40,       32'h6,        0, 0, 32'h100,      1, 0, 0});
    vq.push_back('{0, 0, 0, 1, 32'h40,       32'h5,        0, 0, 32'h44,       1, 0, 0});
    // call / redirect / return
    vq.push_back('{0, 0, 0, 1, 32'h0,        32'h10,       0, 0, 32'h10,       1, 0, 0});
    vq.push_back('{0, 0, 0, 0, 32'h0,        32'h0,        1, 0, 32'h14,       0, 0, 0});
    vq.push_back('{0, 0, 0, 1, 32'h14,       32'hC,        0, 0, 32'h20,       0, 0, 0});
    vq.push_back('{0, 0, 0, 0, 32'h0,        32'h0,        0, 0, 32'h24,       0, 0, 0});
    vq.push_back('{0, 0, 0, 0, 32'h0,        32'h0,        0, 1, 32'h14,       1, 0, 0});
    vq.push_back('{0, 0, 0, 0, 32'h0,        32'h0,        0, 1, 32'h18,       1, 0, 0});
    // five calls into a 4-deep stack, then five returns
    vq.push_back('{0, 0, 0, 1, 32'h0,        32'h0,        0, 0, 32'h0,        1, 0, 0});
    vq.push_back('{0, 0, 0, 0, 32'h0,        32'h0,        1, 0, 32'h4,        0, 0, 0});
    vq.push_back('{0, 0, 0, 1, 32'h0,        32'h10,       0, 0, 32'h10,       0, 0, 0});
    vq.push_back('{0, 0, 0, 0, 32'h0,        32'h0,        1, 0, 32'h14,       0, 0, 0});
    vq.push_back('{0, 0, 0, 1, 32'h0,        32'h20,       0, 0, 32'h20,       0, 0, 0});
    vq.push_back('{0, 0, 0, 0, 32'h0,        32'h0,        1, 0, 32'h24,       0, 0, 0});
    vq.push_back('{0, 0, 0, 1, 32'h0,        32'h30,       0, 0, 32'h30,       0, 0, 0});
    vq.push_back('{0, 0, 0, 0, 32'h0,        32'h0,        1, 0, 32'h34,       0, 1, 0});
    vq.push_back('{0, 0, 0, 1, 32'h0,        32'h40,       0, 0, 32'h40,       0, 1, 0});
    vq.push_back('{0, 0, 0, 0, 32'h0,        32'h0,        1, 0, 32'h44,       0, 1, 0});
    vq.push_back('{0, 0, 0, 0, 32'h0,        32'h0,        0, 1, 32'h44,       0, 0, 0});
    vq.push_back('{0, 0, 0, 0, 32'h0,        32'h0,        0, 1, 32'h34,       0, 0, 0});
    vq.push_back('{0, 0, 0, 0, 32'h0,        32'h0,        0, 1, 32'h24,       0, 0, 0});
    vq.push_back('{0, 0, 0, 0, 32'h0,        32'h0,        0, 1, 32'h14,       1, 0, 0});
    vq.push_back('{0, 0, 0, 0, 32'h0,        32'h0,        0, 1, 32'h18,       1, 0, 0});
    // stall with call+ret held leaves pc and stack alone
    vq.push_back('{0, 0, 0, 0, 32'h0,        32'h0,        1, 0, 32'h1C,       0, 0, 0});
    vq.push_back('{0, 0, 0, 0, 32'h0,        32'h0,        1, 0, 32'h20,       0, 0, 0});
    vq.push_back('{0, 1, 0, 0, 32'h0,        32'h0,        1, 1, 32'h20,       0, 0, 0});
    vq.push_back('{0, 1, 0, 0, 32'h0,        32'h0,        1, 1, 32'h20,       0, 0, 0});
    vq.push_back('{0, 1, 0, 0, 32'h0,        32'h0,        1, 1, 32'h20,       0, 0, 0});
    vq.push_back('{0, 0, 0, 0, 32'h0,        32'h0,        0, 1, 32'h20,       0, 0, 0});
    vq.push_back('{0, 0, 0, 0, 32'h0,        32'h0,        0, 1, 32'h1C,       1, 0, 0});
    vq.push_back('{0, 0, 0, 0, 32'h0,        32'h0,        1, 0, 32'h20,       0, 0, 0});
    vq.push_back('{0, 1, 1, 0, 32'h0,        32'h0,        0, 0, 32'h100,      1, 0, 0});
    vq.push_back('{0, 0, 0, 0, 32'h0,        32'h0,        0, 1, 32'h104,      1, 0, 0});
    // call and ret together
    vq.push_back('{0, 0, 0, 0, 32'h0,        32'h0,        1, 0, 32'h108,      0, 0, 0});
    vq.push_back('{0, 0, 0, 0, 32'h0,        32'h0,        1, 1, 32'h108,      0, 0, 0});
    vq.push_back('{0, 0, 0, 0, 32'h0,        32'h0,        0, 1, 32'h10C,      1, 0, 0});
    vq.push_back('{0, 0, 0, 0, 32'h0,        32'h0,        1, 1, 32'h110,      0, 0, 0});
    vq.push_back('{0, 0, 0, 0, 32'h0,        32'h0,        0, 1, 32'h110,      1, 0, 0});
    // redirect beats ret and leaves the stack untouched
    vq.push_back('{0, 0, 0, 0, 32'h0,        32'h0,        1, 0, 32'h114,      0, 0, 0});
    vq.push_back('{0, 0, 0, 1, 32'h0,        32'h200,      0, 1, 32'h200,      0, 0, 0});
    vq.push_back('{0, 0, 0, 0, 32'h0,        32'h0,        0, 1, 32'h114,      1, 0, 0});
    // wrap-around and carry discard
    vq.push_back('{0, 0, 0, 1, 32'hFFFF_FFF0,32'hC,        0, 0, 32'hFFFF_FFFC,1, 0, 0});
    vq.push_back('{0, 0, 0, 0, 32'h0,        32'h0,        0, 0, 32'h0,        1, 0, 0});
    vq.push_back('{0, 0, 0, 1, 32'hFFFF_FFF0,32'h20,       0, 0, 32'h10,       1, 0, 0});
    // reset mid-operation, redirect beats stall
    vq.push_back('{0, 0, 0, 0, 32'h0,        32'h0,        1, 0, 32'h14,       0, 0, 0});
    vq.push_back('{1, 0, 1, 1, 32'h0,        32'h80,       1, 0, 32'h0,        1, 0, 0});
    vq.push_back('{0, 0, 0, 0, 32'h0,        32'h0,        0, 0, 32'h4,        1, 0, 0});
    vq.push_back('{0, 1, 0, 1, 32'h0,        32'h80,       0, 0, 32'h80,       1, 0, 0});
    vq.push_back('{0, 1, 0, 0, 32'h0,        32'h0,        0, 0, 32'h80,       1, 0, 0});

    foreach (vq[i]) begin
      step(vq[i].rst, vq[i].stl, vq[i].trp, vq[i].rv, vq[i].base, vq[i].imm,
           vq[i].cl, vq[i].rt);
      chk("pc",         i, bus.pc,                  vq[i].e_pc);
      chk("pc_plus4",   i, bus.pc_plus4,            vq[i].e_pc + 32'd4);
      chk("ras_empty",  i, 32'(bus.ras_empty),      32'(vq[i].e_emp));
      chk("ras_full",   i, 32'(bus.ras_full),       32'(vq[i].e_full));
      chk("misaligned", i, 32'(bus.misaligned),     32'(vq[i].e_mis));
    end

    // misaligned pulse lasts exactly one cycle even while pc is held
    step(0, 0, 0, 1, 32'h80, 32'h2, 0, 0);
    chk("seq_mis_pc",    100, bus.pc,              32'h100);
    chk("seq_mis_set",   100, 32'(bus.misaligned), 32'd1);
    step(0, 1, 0, 0, 32'h0, 32'h0, 0, 0);
    chk("seq_hold_pc",   101, bus.pc,              32'h100);
    chk("seq_mis_clr",   101, 32'(bus.misaligned), 32'd0);

    // pc_plus4 wraps at the top of the address space
    step(0, 0, 0, 1, 32'h0, 32'hFFFF_FFFC, 0, 0);
    chk("seq_top_pc",    102, bus.pc,              32'hFFFF_FFFC);
    chk("seq_top_plus4", 102, bus.pc_plus4,        32'h0);
    step(0, 1, 0, 0, 32'h0, 32'h0, 1, 0);
    chk("seq_stall_pc",  103, bus.pc,              32'hFFFF_FFFC);
    chk("seq_stall_ras", 103, 32'(bus.ras_empty),  32'd1);
    step(0, 0, 0, 0, 32'h0, 32'h0, 0, 0);
    chk("seq_wrap_pc",   104, bus.pc,              32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
